// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the 7-segment hex display path.
//   NUM_DIGITS   : digits on the display (one per nibble of a 32-bit word)
//   HEX2SEG_TBL  : active-low {g,f,e,d,c,b,a} pattern per hex nibble
//   SEG_BLANK    : all segments off
//   AN_OFF       : all digit enables off
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Entry [n] is the pattern for nibble n; listed F down to 0.
  localparam logic [15:0][6:0] HEX2SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // 32-bit word viewed as 8 nibbles, nibble 0 least significant.
  typedef logic [NUM_DIGITS-1:0][3:0] nib_word_t;

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7 -- combinational hex nibble to active-low 7-segment decoder.
//   nib_i : 4-bit hex value
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX2SEG_TBL[nib_i];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed 8-digit common-anode hex display driver.
// The displayed word is snapshotted only at frame boundaries so a frame never
// mixes digits from two different words.
//   clk        : board clock, rising edge
//   reset      : asynchronous, active-low
//   value      : word to display, may change any cycle
//   hold       : 1 = keep current snapshot at frame boundaries
//   an         : digit enables, active-low, an[i] = nibble i
//   seg        : segments {g..a}, active-low
//   frame_done : one-cycle pulse at each frame boundary
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank digits above the
// most significant non-zero nibble (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  nib_word_t        shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             fd_q, fd_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic       blank;

  assign tick      = (cnt_q == CNT_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);
  assign cur_nib   = shadow_q[idx_q];

  hex_to_seg7 u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Index of the most significant non-zero nibble; 0 when the word is zero
  // so digit 0 always stays lit.
  logic [IDX_W-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (shadow_q[i] != 4'h0) msd = IDX_W'(i);
  end
  assign blank = (idx_q > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d    = tick ? idx_q + IDX_W'(1) : idx_q;
    shadow_d = (frame_end && !hold) ? nib_word_t'(value) : shadow_q;
    fd_d     = frame_end;
    // Blanked slots keep their time slot so per-digit brightness is uniform.
    an_d     = blank ? AN_OFF    : ~(8'(1) << idx_q);
    seg_d    = blank ? SEG_BLANK : cur_seg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fd_q     <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan -- directed self-checking bench for seg7_scan (SCAN_DIV=4).
// Frames are tracked by cycle position c=1..32 after a boundary edge: the
// digit shown at cycle c is (c-1)/4, and frame_done is high only at c=32.
module tb_seg7_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        hold;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        tog_en = 1'b0;

  int total = 0;
  int bad   = 0;

  // Hand-written decode table, independent of the design package.
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan #(.SCAN_DIV(DIV), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .hold       (hold),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Anti-tear stimulus: flip value every cycle between 0 and 88888888.
  always @(negedge clk)
    if (tog_en) value = (value == 32'h0) ? 32'h8888_8888 : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int top_digit(input logic [31:0] w);
    int m = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 8; i++)
      if (w[4*i +: 4] != 4'h0) m = i;
`else
    m = 7;
`endif
    return m;
  endfunction

  function automatic logic [7:0] an_exp(input logic [31:0] w, input int d);
    logic [7:0] one = 8'h01;
    if (d > top_digit(w)) return 8'hFF;
    return ~(one << d);
  endfunction

  function automatic logic [6:0] seg_exp(input logic [31:0] w, input int d);
    if (d > top_digit(w)) return 7'h7F;
    return seg_ref[w[4*d +: 4]];
  endfunction

  // Check cycles c0..32 of a frame showing word w. After the check at cycle
  // chg_c (0 = never), apply new value/hold/toggle settings.
  task automatic check_frame(input logic [31:0] w, input int c0, input int chg_c,
                             input logic [31:0] nv, input logic nh, input logic nt);
    for (int c = c0; c <= 32; c++) begin
      int d;
      step();
      d = (c - 1) / DIV;
      chk($sformatf("an[%h c%0d]", w, c), {24'h0, an}, {24'h0, an_exp(w, d)});
      chk($sformatf("seg[%h c%0d]", w, c), {25'h0, seg}, {25'h0, seg_exp(w, d)});
      chk($sformatf("fd[%h c%0d]", w, c), {31'h0, frame_done}, {31'h0, (c == 32)});
      if (c == chg_c) begin
        value  = nv;
        hold   = nh;
        tog_en = nt;
      end
    end
  endtask

  initial begin
    logic [31:0] tw;
    reset = 1'b0;
    value = 32'h0;
    hold  = 1'b0;

    // Reset state held over several edges.
    repeat (3) step();
    chk("rst_an",  {24'h0, an},  32'hFF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_fd",  {31'h0, frame_done}, 32'h0);
    @(negedge clk) reset = 1'b1;

    // First frame shows zeros; new value arrives mid-frame, captured at c=32.
    check_frame(32'h0, 1, 18, 32'h1234_ABCD, 1'b0, 1'b0);
    // Capture shown; freeze with hold=1 and a new value.
    check_frame(32'h1234_ABCD, 1, 29, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_frame(32'h1234_ABCD, 1, 0, 32'h0, 1'b0, 1'b0);
    check_frame(32'h1234_ABCD, 1, 0, 32'h0, 1'b0, 1'b0);
    // Release hold before the next boundary.
    check_frame(32'h1234_ABCD, 1, 29, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // All F; start the per-cycle toggle just before the boundary.
    check_frame(32'hFFFF_FFFF, 1, 29, 32'h0, 1'b0, 1'b1);

    // Anti-tear: captured word is one of the two, and the whole frame matches it.
    step();
    chk("tear_d0", {31'h0, (seg == 7'h40) || (seg == 7'h00)}, 32'h1);
    tw = (seg == 7'h00) ? 32'h8888_8888 : 32'h0;
    chk("tear_an0", {24'h0, an}, 32'hFE);
    chk("tear_fd0", {31'h0, frame_done}, 32'h0);
    check_frame(tw, 2, 0, 32'h0, 1'b0, 1'b1);
    tog_en = 1'b0;
    value  = 32'h1234_5678;

    // Async reset off-edge while digit 5 is active.
    repeat (21) step();
    #2 reset = 1'b0;
    #1;
    chk("arst_an",  {24'h0, an},  32'hFF);
    chk("arst_seg", {25'h0, seg}, 32'h7F);
    chk("arst_fd",  {31'h0, frame_done}, 32'h0);
    step();
    chk("arst_an2", {24'h0, an}, 32'hFF);
    @(negedge clk) reset = 1'b1;

    // Restart from digit 0 with shadow=0 although value is non-zero.
    check_frame(32'h0, 1, 10, 32'h1234_5678, 1'b0, 1'b0);
    check_frame(32'h1234_5678, 1, 10, 32'h0000_00A5, 1'b0, 1'b0);
    check_frame(32'h0000_00A5, 1, 10, 32'h0, 1'b0, 1'b0);
    check_frame(32'h0, 1, 0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
